// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control/datapath bundle for the multi-cycle MIPS sequencer
// Ports: opcode/zero/mem_ready flow datapath->controller; enables, mux selects,
// exception and debug state flow controller->datapath.
// master = controller side, slave = datapath side.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       exception;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, exception, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, exception, state
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore FSM sequencing a shared multi-cycle MIPS datapath
// Ports: clk, rst_n (sync, active low); bus (master modport): opcode, zero,
// mem_ready in; PC/IR/regfile/memory enables, mux selects, alu_op,
// exception pulse and debug state out.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_control_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EX     = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ADDI_EX  = 4'd10,
    ADDI_WB  = 4'd11,
    EXC      = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  state_t     state_q, state_d;
  logic [CNT_W-1:0] wd_cnt;
  logic       wd_limit;
  logic       mem_wait;

  logic       pc_write, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, exception;
  logic [1:0] pc_src, alu_src_b, alu_op;

  // Watchdog fires on the last allowed stall cycle; mem_ready that same
  // cycle is checked first in the FSM, so a late answer still wins.
  assign wd_limit = (wd_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign mem_wait = ((state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR))
                    && !bus.mem_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      wd_cnt  <= '0;
    end else begin
      state_q <= state_d;
      // Only keep counting while stalled and staying put; any exit clears it.
      wd_cnt  <= (mem_wait && (state_d == state_q)) ? wd_cnt + CNT_W'(1) : '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    exception  = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = DECODE;
        else if (wd_limit) state_d = EXC;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW:   state_d = MEM_ADDR;
          OP_R:           state_d = R_EX;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_ADDI:        state_d = ADDI_EX;
          OP_J:           state_d = JUMP;
          default:        state_d = EXC;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) state_d = MEM_WB;
        else if (wd_limit) state_d = EXC;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (bus.mem_ready) state_d = FETCH;
        else if (wd_limit) state_d = EXC;
      end
      R_EX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = FETCH;
      end
      ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_write  = ((bus.opcode == OP_BEQ) && bus.zero) ||
                    ((bus.opcode == OP_BNE) && !bus.zero);
        state_d   = FETCH;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        state_d  = FETCH;
      end
      EXC: begin
        exception = 1'b1;
        pc_write  = 1'b1;
        pc_src    = 2'b11;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign bus.pc_write   = pc_write;
  assign bus.pc_src     = pc_src;
  assign bus.iord       = iord;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_write  = reg_write;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.exception  = exception;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control #(.MEM_TIMEOUT(TMO), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", longint'(bus.state), 0);
    chk("rst_mem_read", longint'(bus.mem_read), 1);
    chk("rst_reg_write", longint'(bus.reg_write), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Expected behaviour of one instruction, derived from the instruction class
  // and the memory stall counts (fs: fetch, ds: data access).
  longint e_tr, e_pcw;
  int e_cyc, e_irw, e_rw, e_wb, e_mw, e_mr, e_exc;

  task automatic push(input int s);
    e_tr = e_tr * 16 + s;
    e_cyc++;
  endtask

  task automatic pcw(input int src);
    e_pcw = e_pcw * 5 + src + 1;
  endtask

  task automatic model(input int op, input bit z, input int fs, input int ds);
    int st;
    e_tr = 0; e_pcw = 0; e_cyc = 0; e_irw = 0; e_rw = 0; e_wb = 3;
    e_mw = 0; e_mr = 0; e_exc = 0;
    if (fs >= TMO) begin
      repeat (TMO) push(0);
      e_mr += TMO;
      push(12); e_exc++; pcw(3);
      return;
    end
    repeat (fs + 1) push(0);
    e_mr += fs + 1; e_irw = 1; pcw(0);
    push(1);
    if (op == 35 || op == 43) begin
      push(2);
      st = (op == 35) ? 3 : 5;
      if (ds >= TMO) begin
        repeat (TMO) push(st);
        if (op == 35) e_mr += TMO; else e_mw += TMO;
        push(12); e_exc++; pcw(3);
      end else begin
        repeat (ds + 1) push(st);
        if (op == 35) begin
          e_mr += ds + 1;
          push(4); e_rw++; e_wb = 1;
        end else e_mw += ds + 1;
      end
    end else if (op == 0) begin
      push(6); push(7); e_rw++; e_wb = 2;
    end else if (op == 8) begin
      push(10); push(11); e_rw++; e_wb = 0;
    end else if (op == 4 || op == 5) begin
      push(8);
      if ((op == 4) == z) pcw(1);
    end else if (op == 2) begin
      push(9); pcw(2);
    end else begin
      push(12); e_exc++; pcw(3);
    end
  endtask

  // Runs one instruction from FETCH back to FETCH, driving mem_ready from the
  // stall plan, and compares the observed activity with the model.
  task automatic run_tx(input string tag, input int op, input bit z, input int fs, input int ds);
    longint o_tr, o_pcw;
    int o_cyc, o_irw, o_rw, o_wb, o_mw, o_mr, o_exc, o_mwi;
    int prev, cis, last;
    bit done;
    model(op, z, fs, ds);
    bus.opcode = 6'(op);
    bus.zero = z;
    o_tr = 0; o_pcw = 0; o_cyc = 0; o_irw = 0; o_rw = 0; o_wb = 3;
    o_mw = 0; o_mr = 0; o_exc = 0; o_mwi = 0;
    prev = 15; cis = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (int'(bus.state) == prev) cis++; else cis = 0;
      prev = int'(bus.state);
      if (prev == 0) bus.mem_ready = (cis >= fs);
      else if (prev == 3 || prev == 5) bus.mem_ready = (cis >= ds);
      else bus.mem_ready = 1'($urandom);
      #1;
      o_tr = o_tr * 16 + longint'(bus.state);
      o_cyc++;
      if (bus.ir_write) o_irw++;
      if (bus.reg_write) begin o_rw++; o_wb = {bus.reg_dst, bus.mem_to_reg}; end
      if (bus.mem_write) o_mw++;
      if (bus.mem_write && bus.iord) o_mwi++;
      if (bus.mem_read) o_mr++;
      if (bus.exception) o_exc++;
      if (bus.pc_write) o_pcw = o_pcw * 5 + bus.pc_src + 1;
      last = int'(bus.state);
      @(posedge clk);
      #1;
      if (bus.state == 4'd0 && last != 0) done = 1;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_trace"}, o_tr, e_tr);
    chk({tag, "_cycles"}, o_cyc, e_cyc);
    chk({tag, "_ir_write"}, o_irw, e_irw);
    chk({tag, "_reg_write"}, o_rw, e_rw);
    chk({tag, "_wb_sel"}, o_wb, e_wb);
    chk({tag, "_mem_write"}, o_mw, e_mw);
    chk({tag, "_mw_iord"}, o_mwi, e_mw);
    chk({tag, "_mem_read"}, o_mr, e_mr);
    chk({tag, "_exception"}, o_exc, e_exc);
    chk({tag, "_pc_write"}, o_pcw, e_pcw);
    if (!done) do_reset();
  endtask

  int ops[7] = '{35, 43, 0, 4, 5, 8, 2};

  initial begin
    int op, fs, ds;
    bit rw_seen, ok;
    bus.opcode = 6'd35;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    do_reset();

    run_tx("lw_nostall", 35, 0, 0, 0);
    chk("lw_state_seq", e_tr, 64'h01234);
    run_tx("beq_z1", 4, 1, 0, 0);
    run_tx("beq_z0", 4, 0, 0, 0);
    run_tx("bne_z1", 5, 1, 0, 0);
    run_tx("bne_z0", 5, 0, 0, 0);
    run_tx("sw_stall3", 43, 0, 0, 3);
    run_tx("fetch_timeout", 35, 0, 99, 0);
    run_tx("illegal_3f", 63, 0, 0, 0);
    run_tx("fetch_ready_at_limit", 0, 0, TMO - 1, 0);
    run_tx("lw_rd_timeout", 35, 0, 1, TMO);
    run_tx("sw_wr_timeout", 43, 0, 0, 7);
    run_tx("addi", 8, 0, 2, 0);
    run_tx("jump", 2, 1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) op = ops[$urandom_range(0, 6)];
      else op = int'($urandom_range(0, 63));
      fs = (i % 5 == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 2));
      ds = int'($urandom_range(0, 5));
      run_tx($sformatf("rnd%0d", i), op, 1'($urandom), fs, ds);
    end

    // Reset during R_EX abandons the instruction before its write-back.
    bus.opcode = 6'd0;
    rw_seen = 0;
    ok = 0;
    for (int c = 0; c < 12 && !ok; c++) begin
      @(negedge clk);
      bus.mem_ready = 1'b1;
      #1;
      if (bus.reg_write) rw_seen = 1;
      if (bus.state == 4'd6) begin
        rst_n = 1'b0;
        ok = 1;
      end
    end
    chk("rst_mid_reached_r_ex", ok, 1);
    @(posedge clk);
    #1;
    chk("rst_mid_state", longint'(bus.state), 0);
    if (bus.reg_write) rw_seen = 1;
    chk("rst_mid_no_reg_write", rw_seen, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench time limit");
  end
endmodule
